// File: rtl/midi_pkg.sv
// Shared definitions for the MIDI receiver: register map, STATUS bit positions,
// receive FSM states and the STATUS packing helper.
package midi_pkg;

  localparam logic REG_DATA   = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  localparam int ST_AVAIL = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVR   = 2;
  localparam int ST_FE    = 3;
  localparam int ST_IRQEN = 7;

  localparam logic [7:0] MIDI_ACTIVE_SENSE = 8'hFE;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

  function automatic logic [7:0] pack_status(input logic avail, input logic full,
                                             input logic ovr, input logic fe,
                                             input logic irq_en);
    logic [7:0] s;
    s           = 8'h00;
    s[ST_AVAIL] = avail;
    s[ST_FULL]  = full;
    s[ST_OVR]   = ovr;
    s[ST_FE]    = fe;
    s[ST_IRQEN] = irq_en;
    return s;
  endfunction

endpackage

// File: rtl/midi_rx_fifo.sv
// Small synchronous byte FIFO; head is visible combinationally on dout.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module midi_rx_fifo #(
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic [FIFO_DEPTH_LOG2:0] count,
  output logic                     full,
  output logic                     empty
);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

  logic [7:0]                 mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [FIFO_DEPTH_LOG2:0]   count_reg;
  logic                       do_push;
  logic                       do_pop;

  assign empty   = (count_reg == '0);
  assign full    = count_reg[FIFO_DEPTH_LOG2];
  assign count   = count_reg;
  assign dout    = mem[rd_ptr_reg];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/midi_rx_uart.sv
// MIDI 8N1 receiver with byte FIFO and a DATA/STATUS CPU register window.
// Build option: define MIDI_ACTIVE_SENSE_FILTER_EN to discard received 0xFE bytes.
module midi_rx_uart
  import midi_pkg::*;
#(
  parameter int DIV_16X         = 16,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rxd,
  input  logic       cs,
  input  logic       strobe,
  input  logic       r_w,
  input  logic       addr,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       rd_en,
  output logic       irq
);
  localparam int TW = (DIV_16X > 1) ? $clog2(DIV_16X) : 1;

  logic [1:0]               sync_reg;
  logic                     line_prev_reg;
  logic                     line;
  logic                     fall;
  logic                     start_edge;
  logic                     tick;
  logic [TW-1:0]            tick_cnt_reg;
  rx_state_t                state_reg, state_next;
  logic [3:0]               sub_reg, sub_next;
  logic [2:0]               bit_reg, bit_next;
  logic [7:0]               shift_reg, shift_next;
  logic                     byte_done;
  logic                     frame_err;
  logic                     push_req;
  logic                     rd_sel;
  logic                     st_wr;
  logic                     overrun_set;
  logic                     ovr_reg, fe_reg, irq_en_reg, irq_reg;
  logic [7:0]               fifo_dout;
  logic [FIFO_DEPTH_LOG2:0] fifo_count;
  logic                     fifo_full, fifo_empty;
  logic                     avail;
  logic [7:0]               status;
  logic                     unused_wr_bits;

  assign line       = sync_reg[1];
  assign fall       = line_prev_reg & ~line;
  assign start_edge = (state_reg == IDLE) & fall;
  assign tick       = (tick_cnt_reg == TW'(DIV_16X - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_reg      <= 2'b11;
      line_prev_reg <= 1'b1;
    end else begin
      sync_reg      <= {sync_reg[0], rxd};
      line_prev_reg <= line;
    end
  end

  // Re-phasing on the start edge puts every sample near the bit centre.
  always_ff @(posedge clock) begin
    if (reset || start_edge || tick) tick_cnt_reg <= '0;
    else                             tick_cnt_reg <= tick_cnt_reg + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      sub_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      sub_reg   <= sub_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sub_next   = sub_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    byte_done  = 1'b0;
    frame_err  = 1'b0;
    case (state_reg)
      IDLE: if (fall) begin
        state_next = START;
        sub_next   = '0;
      end
      START: if (tick) begin
        if (sub_reg == 4'd7) begin
          sub_next   = '0;
          bit_next   = '0;
          state_next = line ? IDLE : DATA;
        end else sub_next = sub_reg + 1'b1;
      end
      DATA: if (tick) begin
        if (sub_reg == 4'd15) begin
          sub_next   = '0;
          shift_next = {line, shift_reg[7:1]};
          if (bit_reg == 3'd7) state_next = STOP;
          else                 bit_next   = bit_reg + 1'b1;
        end else sub_next = sub_reg + 1'b1;
      end
      STOP: if (tick) begin
        if (sub_reg == 4'd15) begin
          sub_next   = '0;
          byte_done  = line;
          frame_err  = ~line;
          state_next = line ? IDLE : BREAK;
        end else sub_next = sub_reg + 1'b1;
      end
      BREAK: if (tick) begin
        // Any low sample restarts the run of idle ticks.
        if (!line)                 sub_next = '0;
        else if (sub_reg == 4'd15) begin
          sub_next   = '0;
          state_next = IDLE;
        end else sub_next = sub_reg + 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef MIDI_ACTIVE_SENSE_FILTER_EN
  assign push_req = byte_done & (shift_reg != MIDI_ACTIVE_SENSE);
`else
  assign push_req = byte_done;
`endif

  assign rd_sel      = cs & strobe & r_w & (addr == REG_DATA);
  assign st_wr       = cs & strobe & ~r_w & (addr == REG_STATUS);
  assign overrun_set = push_req & fifo_full & ~rd_sel;
  assign avail       = |fifo_count;

  midi_rx_fifo #(.FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_req),
    .pop   (rd_sel),
    .din   (shift_reg),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A flag event in the same cycle as a write-1-to-clear keeps the flag set.
  always_ff @(posedge clock) begin
    if (reset) begin
      ovr_reg    <= 1'b0;
      fe_reg     <= 1'b0;
      irq_en_reg <= 1'b0;
      irq_reg    <= 1'b0;
    end else begin
      if (st_wr) irq_en_reg <= wr_data[ST_IRQEN];
      if (overrun_set)                 ovr_reg <= 1'b1;
      else if (st_wr & wr_data[ST_OVR]) ovr_reg <= 1'b0;
      if (frame_err)                   fe_reg  <= 1'b1;
      else if (st_wr & wr_data[ST_FE]) fe_reg  <= 1'b0;
      irq_reg <= irq_en_reg & (avail | ovr_reg | fe_reg);
    end
  end

  assign unused_wr_bits = ^{wr_data[6:4], wr_data[1:0]};

  assign status = pack_status(avail, fifo_full, ovr_reg, fe_reg, irq_en_reg);
  assign rd_en  = cs & r_w;
  assign irq    = irq_reg;

  always_comb begin
    rd_data = 8'h00;
    if (rd_en) begin
      if (addr == REG_STATUS) rd_data = status;
      else if (!fifo_empty)   rd_data = fifo_dout;
    end
  end

endmodule

// File: tb/tb_midi_rx_uart.sv
// Bench for midi_rx_uart: queue-based reference model checked every cycle,
// plus directed frames with literal expectations and a randomized section.
`timescale 1ns/1ps
module tb_midi_rx_uart;
  localparam int DIV     = 16;
  localparam int BIT_CYC = 16 * DIV;
  // start edge -> stop-bit decision: 2 sync flops + 1 edge cycle, then 8+8*16+16 ticks
  localparam int LAT     = 3 + 152 * DIV;
  localparam int DEPTH   = 4;
`ifdef MIDI_ACTIVE_SENSE_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rxd = 1'b1;
  logic       cs = 1'b0;
  logic       strobe = 1'b0;
  logic       r_w = 1'b0;
  logic       addr = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] rd_data;
  logic       rd_en;
  logic       irq;

  midi_rx_uart #(.DIV_16X(DIV), .FIFO_DEPTH_LOG2(2)) dut (
    .clock(clock), .reset(reset), .rxd(rxd), .cs(cs), .strobe(strobe),
    .r_w(r_w), .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
    .rd_en(rd_en), .irq(irq)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    int         due;
    logic [7:0] b;
    logic       ok;
  } ev_t;
  ev_t        evq[$];
  logic [7:0] mq[$];
  logic       m_ovr = 1'b0, m_fe = 1'b0, m_irq_en = 1'b0, irq_exp = 1'b0;
  bit         chk_en = 1'b0;
  bit         m_pop, m_push, m_fe_set, m_ovr_set, m_sw, m_full0;
  logic [7:0] m_pb, cmp_exp;

  function automatic logic [7:0] m_status();
    return {m_irq_en, 3'b000, m_fe, m_ovr, mq.size() == DEPTH, mq.size() != 0};
  endfunction

  // Reference model: byte queue plus three flags, advanced once per clock.
  always @(posedge clock) begin
    cyc = cyc + 1;
    if (reset) begin
      mq.delete();
      evq.delete();
      m_ovr = 1'b0; m_fe = 1'b0; m_irq_en = 1'b0; irq_exp = 1'b0;
      chk_en = 1'b1;
    end else begin
      irq_exp  = m_irq_en & ((mq.size() != 0) | m_ovr | m_fe);
      m_push   = 1'b0; m_fe_set = 1'b0; m_pb = 8'h00;
      if (evq.size() != 0 && evq[0].due == cyc) begin
        if (!evq[0].ok) m_fe_set = 1'b1;
        else if (!(FILTER && evq[0].b == 8'hFE)) begin
          m_push = 1'b1;
          m_pb   = evq[0].b;
        end
        void'(evq.pop_front());
      end
      m_pop   = cs && strobe && r_w && !addr && (mq.size() != 0);
      m_sw    = cs && strobe && !r_w && addr;
      m_full0 = (mq.size() == DEPTH);
      if (m_pop) void'(mq.pop_front());
      m_ovr_set = 1'b0;
      if (m_push) begin
        if (m_full0 && !m_pop) m_ovr_set = 1'b1;
        else mq.push_back(m_pb);
      end
      if (m_sw) begin
        m_irq_en = wr_data[7];
        if (wr_data[2]) m_ovr = 1'b0;
        if (wr_data[3]) m_fe = 1'b0;
      end
      if (m_ovr_set) m_ovr = 1'b1;
      if (m_fe_set)  m_fe = 1'b1;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      vectors++;
      if (rd_en !== (cs & r_w)) begin
        miscompares++;
        $display("FAIL rd_en cyc=%0d got=%b want=%b", cyc, rd_en, cs & r_w);
      end
      vectors++;
      if (irq !== irq_exp) begin
        miscompares++;
        $display("FAIL irq cyc=%0d got=%b want=%b", cyc, irq, irq_exp);
      end
      if (cs && r_w) begin
        cmp_exp = addr ? m_status() : ((mq.size() != 0) ? mq[0] : 8'h00);
        vectors++;
        if (rd_data !== cmp_exp) begin
          miscompares++;
          $display("FAIL rd_data addr=%0d cyc=%0d got=%02h want=%02h", addr, cyc, rd_data, cmp_exp);
        end
      end
    end
  end

  task automatic tick_wait(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got=%02h want=%02h", name, got, want);
    end
  endtask

  task automatic bus(input logic rw, input logic a, input logic [7:0] wd, output logic [7:0] rdv);
    @(posedge clock); #1;
    cs = 1'b1; strobe = 1'b1; r_w = rw; addr = a; wr_data = wd;
    @(negedge clock);
    rdv = rd_data;
    @(posedge clock); #1;
    cs = 1'b0; strobe = 1'b0; r_w = 1'b0; addr = 1'b0; wr_data = 8'h00;
    if (rw) $display("bus read  %s = %02h (cycle %0d)", a ? "STATUS" : "DATA  ", rdv, cyc);
    else    $display("bus write %s <= %02h (cycle %0d)", a ? "STATUS" : "DATA  ", wd, cyc);
  endtask

  task automatic rd_check(input logic a, input logic [7:0] want, input string name);
    logic [7:0] v;
    bus(1'b1, a, 8'h00, v);
    check8(name, v, want);
  endtask

  task automatic wr(input logic a, input logic [7:0] d);
    logic [7:0] v;
    bus(1'b0, a, d, v);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int gap);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    @(posedge clock); #1;
    evq.push_back(ev_t'{due: cyc + LAT, b: b, ok: stop_bit});
    $display("frame %02h stop=%b start cycle %0d", b, stop_bit, cyc);
    for (int i = 0; i < 10; i++) begin
      rxd = bits[i];
      tick_wait(BIT_CYC);
    end
    rxd = 1'b1;
    tick_wait(gap);
  endtask

  task automatic random_ops(input int n);
    logic [7:0] v;
    repeat (n) begin
      tick_wait($urandom_range(50, 500));
      case ($urandom_range(0, 4))
        0: bus(1'b1, 1'b0, 8'h00, v);
        1: bus(1'b1, 1'b1, 8'h00, v);
        2: bus(1'b0, 1'b1, 8'($urandom) & 8'h8C, v);
        3: begin
          cs = 1'b1; r_w = 1'b1; addr = 1'($urandom);
          tick_wait(3);
          cs = 1'b0; r_w = 1'b0; addr = 1'b0;
        end
        default: bus(1'b0, 1'b0, 8'($urandom), v);
      endcase
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    logic [7:0] v;
    logic [7:0] rb;
    logic       ok;

    tick_wait(5);
    reset = 1'b0;
    tick_wait(2);
    check8("reset_irq", {7'b0, irq}, 8'h00);
    check8("reset_rd_en", {7'b0, rd_en}, 8'h00);
    rd_check(1'b1, 8'h00, "reset_status");

    send_frame(8'h90, 1'b1, 20);
    rd_check(1'b1, 8'h01, "f90_status");
    rd_check(1'b0, 8'h90, "f90_data");
    rd_check(1'b1, 8'h00, "f90_status_after");

    @(posedge clock); #1;
    rxd = 1'b0;
    tick_wait(3);
    rxd = 1'b1;
    tick_wait(300);
    rd_check(1'b1, 8'h00, "glitch_status");

    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 10);
    rd_check(1'b1, 8'h07, "ovr_status");
    for (int i = 1; i <= 4; i++) rd_check(1'b0, 8'(i), "ovr_data");
    rd_check(1'b0, 8'h00, "empty_data");
    rd_check(1'b1, 8'h04, "ovr_flag_only");
    wr(1'b1, 8'h04);
    rd_check(1'b1, 8'h00, "ovr_cleared");

    send_frame(8'h3C, 1'b0, 400);
    rd_check(1'b1, 8'h08, "fe_status");
    send_frame(8'h3C, 1'b1, 20);
    rd_check(1'b1, 8'h09, "fe_then_ok_status");
    rd_check(1'b0, 8'h3C, "fe_then_ok_data");
    wr(1'b1, 8'h08);
    rd_check(1'b1, 8'h00, "fe_cleared");

    wr(1'b1, 8'h80);
    fork
      send_frame(8'h45, 1'b1, 20);
      begin
        @(posedge clock); #1;
        tick_wait(LAT);
        check8("irq_at_push", {7'b0, irq}, 8'h00);
        tick_wait(1);
        check8("irq_after_push", {7'b0, irq}, 8'h01);
      end
    join
    rd_check(1'b0, 8'h45, "irq_data");
    check8("irq_on_pop_edge", {7'b0, irq}, 8'h01);
    tick_wait(2);
    check8("irq_after_pop", {7'b0, irq}, 8'h00);

    send_frame(8'hFE, 1'b1, 20);
    rd_check(1'b1, FILTER ? 8'h80 : 8'h81, "fe_byte_status");
    rd_check(1'b0, FILTER ? 8'h00 : 8'hFE, "fe_byte_data");
    wr(1'b1, 8'h00);

    fork
      send_frame(8'hF0, 1'b1, 20);
      begin
        @(posedge clock); #1;
        tick_wait(5 * BIT_CYC + 100);
        reset = 1'b1;
        tick_wait(2);
        reset = 1'b0;
      end
    join
    rd_check(1'b1, 8'h00, "after_reset_status");
    send_frame(8'h7F, 1'b1, 20);
    rd_check(1'b1, 8'h01, "f7f_status");
    rd_check(1'b0, 8'h7F, "f7f_data");

    send_frame(8'h11, 1'b1, 10);
    send_frame(8'h22, 1'b1, 10);
    send_frame(8'h33, 1'b1, 10);
    send_frame(8'h44, 1'b1, 10);
    rd_check(1'b1, 8'h03, "full_status");
    fork
      send_frame(8'hA5, 1'b1, 20);
      begin
        @(posedge clock); #1;
        d = cyc + LAT;
        while (cyc != d - 2) tick_wait(1);
        bus(1'b1, 1'b0, 8'h00, v);
        check8("pushpop_full_data", v, 8'h11);
      end
    join
    rd_check(1'b1, 8'h03, "pushpop_full_status");
    rd_check(1'b0, 8'h22, "drain0");
    rd_check(1'b0, 8'h33, "drain1");
    rd_check(1'b0, 8'h44, "drain2");
    rd_check(1'b0, 8'hA5, "drain3");
    rd_check(1'b1, 8'h00, "drained_status");

    for (int r = 0; r < 6; r++) begin
      rb = 8'($urandom);
      ok = ($urandom_range(0, 5) != 0);
      fork
        send_frame(rb, ok, ok ? $urandom_range(0, 40) : 400);
        random_ops(4);
      join
    end
    bus(1'b1, 1'b1, 8'h00, v);
    tick_wait(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
